// File: rtl/neck_power_ctrl.sv
// Welder power-cut sequencer: each accepted neck detect cuts power, restores it, then blanks
// further detects; a windowed cut-rate monitor latches a sticky fault that holds power off.
module neck_power_ctrl #(
    parameter int unsigned CUT_CYCLES    = 20000,
    parameter int unsigned BLANK_CYCLES  = 50000,
    parameter int unsigned WINDOW_CYCLES = 1000000,
    parameter int unsigned FAULT_MAX     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        neck_det,
    input  logic        fault_clr,
    output logic        power_switch,
    output logic        cut_active,
    output logic        fault,
    output logic [15:0] cut_count
);

    localparam int unsigned DLY_MAX = (CUT_CYCLES > BLANK_CYCLES) ? CUT_CYCLES : BLANK_CYCLES;
    localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
    localparam int unsigned WIN_W   = $clog2(WINDOW_CYCLES);
    localparam int unsigned WC_W    = $clog2(FAULT_MAX + 1);

    localparam logic [DLY_W-1:0] CUT_LD   = DLY_W'(CUT_CYCLES);
    localparam logic [DLY_W-1:0] BLANK_LD = DLY_W'(BLANK_CYCLES);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [WC_W-1:0]  TRIP_AT  = WC_W'(FAULT_MAX - 1);
    localparam logic [WC_W-1:0]  WC_ONE   = WC_W'(1);

    typedef enum logic [2:0] {
        S_DISABLED = 3'd0,
        S_ARMED    = 3'd1,
        S_CUT      = 3'd2,
        S_BLANK    = 3'd3,
        S_FAULT    = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WC_W-1:0]   win_cuts_q, win_cuts_d;
    logic [15:0]       cut_count_q, cut_count_d;
    logic              power_q, power_d;
    logic              cut_act_q, cut_act_d;
    logic              fault_q, fault_d;

    logic              wrap;
    logic              dly_done;
    logic              accept;
    logic              trip;
    logic [WC_W-1:0]   win_cuts_eff;

    // A cut accepted on the wrap edge is judged against the already-cleared window count.
    assign wrap         = (win_q == WIN_LAST);
    assign win_cuts_eff = wrap ? '0 : win_cuts_q;
    assign dly_done     = (dly_q == DLY_ONE);
    assign accept       = (state_q == S_ARMED) && en && neck_det;
    assign trip         = accept && (win_cuts_eff >= TRIP_AT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DISABLED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DISABLED: begin
                if (en) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!en)          state_d = S_DISABLED;
                else if (neck_det) state_d = trip ? S_FAULT : S_CUT;
            end
            S_CUT: begin
                if (!en)          state_d = S_DISABLED;
                else if (dly_done) state_d = S_BLANK;
            end
            S_BLANK: begin
                if (!en)          state_d = S_DISABLED;
                else if (dly_done) state_d = S_ARMED;
            end
            S_FAULT: begin
                if (fault_clr) state_d = S_DISABLED;
            end
            default: state_d = S_DISABLED;
        endcase
    end

    // Outputs are decoded from the next state and registered so they change with the state.
    always_comb begin
        power_d   = 1'b0;
        cut_act_d = 1'b0;
        fault_d   = 1'b0;
        case (state_d)
            S_ARMED: power_d   = 1'b1;
            S_BLANK: power_d   = 1'b1;
            S_CUT:   cut_act_d = 1'b1;
            S_FAULT: fault_d   = 1'b1;
            default: power_d   = 1'b0;
        endcase
    end

    always_comb begin
        dly_d = dly_q;
        if (state_d == S_CUT && state_q != S_CUT) begin
            dly_d = CUT_LD;
        end else if (state_d == S_BLANK && state_q != S_BLANK) begin
            dly_d = BLANK_LD;
        end else if (state_q == S_CUT || state_q == S_BLANK) begin
            dly_d = dly_q - DLY_ONE;
        end
    end

    always_comb begin
        win_d      = wrap ? '0 : (win_q + WIN_ONE);
        win_cuts_d = win_cuts_eff;
        if (accept && !trip) begin
            win_cuts_d = win_cuts_eff + WC_ONE;
        end
        cut_count_d = cut_count_q;
        if (accept && cut_count_q != 16'hFFFF) begin
            cut_count_d = cut_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q       <= '0;
            win_cuts_q  <= '0;
            cut_count_q <= '0;
            power_q     <= 1'b0;
            cut_act_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            win_q       <= win_d;
            win_cuts_q  <= win_cuts_d;
            cut_count_q <= cut_count_d;
            power_q     <= power_d;
            cut_act_q   <= cut_act_d;
            fault_q     <= fault_d;
        end
    end

    // The interval counter is always loaded before use, so it needs no reset.
    always_ff @(posedge clk) begin
        dly_q <= dly_d;
    end

    assign power_switch = power_q;
    assign cut_active   = cut_act_q;
    assign fault        = fault_q;
    assign cut_count    = cut_count_q;

endmodule

// File: tb/tb_neck_power_ctrl.sv
// Scoreboard bench for neck_power_ctrl with CUT=4, BLANK=6, WINDOW=100, FAULT_MAX=3.
module tb_neck_power_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        neck_det = 1'b0;
    logic        fault_clr = 1'b0;
    logic        power_switch;
    logic        cut_active;
    logic        fault;
    logic [15:0] cut_count;

    neck_power_ctrl #(
        .CUT_CYCLES   (4),
        .BLANK_CYCLES (6),
        .WINDOW_CYCLES(100),
        .FAULT_MAX    (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .neck_det    (neck_det),
        .fault_clr   (fault_clr),
        .power_switch(power_switch),
        .cut_active  (cut_active),
        .fault       (fault),
        .cut_count   (cut_count)
    );

    always #5 clk = ~clk;

    // stim = {en, neck_det, fault_clr}; exp = {power_switch, cut_active, fault}
    typedef struct packed {
        logic [2:0]  stim;
        logic [2:0]  exp;
        logic [15:0] cc;
    } vec_t;

    vec_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edge_n = 0;

    task automatic push(input int n, input logic [2:0] stim, input logic [2:0] exp,
                        input logic [15:0] cc);
        vec_t v;
        v.stim = stim;
        v.exp  = exp;
        v.cc   = cc;
        for (int i = 0; i < n; i++) sbq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        {en, neck_det, fault_clr} = v.stim;
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        {en, neck_det, fault_clr} = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        vec_t v;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({power_switch, cut_active, fault, cut_count} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_state: got ps=%b ca=%b fault=%b cnt=%0d, want all zero",
                     power_switch, cut_active, fault, cut_count);
        end
        rst_n  = 1'b1;
        edge_n = 0;
        push(2, 3'b000, 3'b000, 16'd0);
        push(1, 3'b100, 3'b100, 16'd0);
        push(1, 3'b000, 3'b000, 16'd0);
        push(1, 3'b100, 3'b100, 16'd0);
        while (sbq.size() > 0) begin
            v = sbq.pop_front();
            drive(v);
            n_vec++;
            if ({power_switch, cut_active, fault, cut_count} !== {v.exp, v.cc}) begin
                n_err++;
                $display("FAIL reset_en e%0d: got ps/ca/flt=%b%b%b cnt=%0d, want %b cnt=%0d",
                         edge_n, power_switch, cut_active, fault, cut_count, v.exp, v.cc);
            end
        end
    endtask

    task automatic test_cut();
        vec_t v;
        do_reset();
        push(9, 3'b100, 3'b100, 16'd0);
        push(1, 3'b110, 3'b010, 16'd1);
        push(3, 3'b100, 3'b010, 16'd1);
        push(1, 3'b100, 3'b100, 16'd1);
        while (sbq.size() > 0) begin
            v = sbq.pop_front();
            drive(v);
            n_vec++;
            if ({power_switch, cut_active, fault, cut_count} !== {v.exp, v.cc}) begin
                n_err++;
                $display("FAIL cut e%0d: got ps/ca/flt=%b%b%b cnt=%0d, want %b cnt=%0d",
                         edge_n, power_switch, cut_active, fault, cut_count, v.exp, v.cc);
            end
        end
    endtask

    task automatic test_blank();
        vec_t v;
        push(2, 3'b100, 3'b100, 16'd1);
        push(1, 3'b110, 3'b100, 16'd1);
        push(2, 3'b100, 3'b100, 16'd1);
        push(1, 3'b110, 3'b100, 16'd1);
        push(1, 3'b110, 3'b010, 16'd2);
        push(3, 3'b100, 3'b010, 16'd2);
        push(6, 3'b100, 3'b100, 16'd2);
        while (sbq.size() > 0) begin
            v = sbq.pop_front();
            drive(v);
            n_vec++;
            if ({power_switch, cut_active, fault, cut_count} !== {v.exp, v.cc}) begin
                n_err++;
                $display("FAIL blank e%0d: got ps/ca/flt=%b%b%b cnt=%0d, want %b cnt=%0d",
                         edge_n, power_switch, cut_active, fault, cut_count, v.exp, v.cc);
            end
        end
    endtask

    task automatic test_fault();
        vec_t v;
        do_reset();
        push(1, 3'b100, 3'b100, 16'd0);
        push(1, 3'b110, 3'b010, 16'd1);
        push(3, 3'b100, 3'b010, 16'd1);
        push(7, 3'b100, 3'b100, 16'd1);
        push(1, 3'b110, 3'b010, 16'd2);
        push(3, 3'b100, 3'b010, 16'd2);
        push(7, 3'b100, 3'b100, 16'd2);
        push(1, 3'b110, 3'b001, 16'd3);
        push(1, 3'b010, 3'b001, 16'd3);
        push(1, 3'b110, 3'b001, 16'd3);
        push(1, 3'b100, 3'b001, 16'd3);
        push(1, 3'b101, 3'b000, 16'd3);
        push(1, 3'b100, 3'b100, 16'd3);
        push(1, 3'b101, 3'b100, 16'd3);
        while (sbq.size() > 0) begin
            v = sbq.pop_front();
            drive(v);
            n_vec++;
            if ({power_switch, cut_active, fault, cut_count} !== {v.exp, v.cc}) begin
                n_err++;
                $display("FAIL fault e%0d: got ps/ca/flt=%b%b%b cnt=%0d, want %b cnt=%0d",
                         edge_n, power_switch, cut_active, fault, cut_count, v.exp, v.cc);
            end
        end
    endtask

    task automatic test_window_wrap();
        vec_t v;
        do_reset();
        push(1, 3'b100, 3'b100, 16'd0);
        push(1, 3'b110, 3'b010, 16'd1);
        push(3, 3'b100, 3'b010, 16'd1);
        push(7, 3'b100, 3'b100, 16'd1);
        push(1, 3'b110, 3'b010, 16'd2);
        push(3, 3'b100, 3'b010, 16'd2);
        push(83, 3'b100, 3'b100, 16'd2);
        push(1, 3'b110, 3'b010, 16'd3);
        while (sbq.size() > 0) begin
            v = sbq.pop_front();
            drive(v);
            n_vec++;
            if ({power_switch, cut_active, fault, cut_count} !== {v.exp, v.cc}) begin
                n_err++;
                $display("FAIL wrap e%0d: got ps/ca/flt=%b%b%b cnt=%0d, want %b cnt=%0d",
                         edge_n, power_switch, cut_active, fault, cut_count, v.exp, v.cc);
            end
        end
        n_vec++;
        if (dut.win_cuts_q !== 2'd1) begin
            n_err++;
            $display("FAIL wrap_win_cuts: got %0d, want 1", dut.win_cuts_q);
        end
        push(3, 3'b100, 3'b010, 16'd3);
        push(7, 3'b100, 3'b100, 16'd3);
        push(1, 3'b110, 3'b010, 16'd4);
        push(3, 3'b100, 3'b010, 16'd4);
        push(7, 3'b100, 3'b100, 16'd4);
        push(1, 3'b110, 3'b001, 16'd5);
        while (sbq.size() > 0) begin
            v = sbq.pop_front();
            drive(v);
            n_vec++;
            if ({power_switch, cut_active, fault, cut_count} !== {v.exp, v.cc}) begin
                n_err++;
                $display("FAIL wrap_after e%0d: got ps/ca/flt=%b%b%b cnt=%0d, want %b cnt=%0d",
                         edge_n, power_switch, cut_active, fault, cut_count, v.exp, v.cc);
            end
        end
    endtask

    task automatic test_en_drop();
        vec_t v;
        do_reset();
        push(1, 3'b100, 3'b100, 16'd0);
        push(1, 3'b110, 3'b010, 16'd1);
        push(2, 3'b000, 3'b000, 16'd1);
        push(1, 3'b100, 3'b100, 16'd1);
        push(1, 3'b010, 3'b000, 16'd1);
        push(1, 3'b100, 3'b100, 16'd1);
        push(1, 3'b110, 3'b010, 16'd2);
        while (sbq.size() > 0) begin
            v = sbq.pop_front();
            drive(v);
            n_vec++;
            if ({power_switch, cut_active, fault, cut_count} !== {v.exp, v.cc}) begin
                n_err++;
                $display("FAIL en_drop e%0d: got ps/ca/flt=%b%b%b cnt=%0d, want %b cnt=%0d",
                         edge_n, power_switch, cut_active, fault, cut_count, v.exp, v.cc);
            end
        end
    endtask

    task automatic test_reset_and_saturate();
        vec_t v;
        do_reset();
        push(1, 3'b100, 3'b100, 16'd0);
        push(1, 3'b110, 3'b010, 16'd1);
        push(3, 3'b100, 3'b010, 16'd1);
        push(2, 3'b100, 3'b100, 16'd1);
        while (sbq.size() > 0) begin
            v = sbq.pop_front();
            drive(v);
            n_vec++;
            if ({power_switch, cut_active, fault, cut_count} !== {v.exp, v.cc}) begin
                n_err++;
                $display("FAIL pre_rst e%0d: got ps/ca/flt=%b%b%b cnt=%0d, want %b cnt=%0d",
                         edge_n, power_switch, cut_active, fault, cut_count, v.exp, v.cc);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({power_switch, cut_active, fault, cut_count} !== 19'd0) begin
            n_err++;
            $display("FAIL async_rst: got ps=%b ca=%b fault=%b cnt=%0d, want all zero",
                     power_switch, cut_active, fault, cut_count);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        edge_n = 0;
        push(1, 3'b100, 3'b100, 16'd0);
        while (sbq.size() > 0) begin
            v = sbq.pop_front();
            drive(v);
            n_vec++;
            if ({power_switch, cut_active, fault, cut_count} !== {v.exp, v.cc}) begin
                n_err++;
                $display("FAIL post_rst e%0d: got ps/ca/flt=%b%b%b cnt=%0d, want %b cnt=%0d",
                         edge_n, power_switch, cut_active, fault, cut_count, v.exp, v.cc);
            end
        end
        {en, neck_det, fault_clr} = 3'b100;
        force dut.cut_count_d = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.cut_count_d;
        edge_n++;
        n_vec++;
        if ({power_switch, cut_count} !== {1'b1, 16'hFFFE}) begin
            n_err++;
            $display("FAIL preload: got ps=%b cnt=%0d, want ps=1 cnt=65534",
                     power_switch, cut_count);
        end
        push(1, 3'b110, 3'b010, 16'hFFFF);
        push(3, 3'b100, 3'b010, 16'hFFFF);
        push(7, 3'b100, 3'b100, 16'hFFFF);
        push(1, 3'b110, 3'b010, 16'hFFFF);
        while (sbq.size() > 0) begin
            v = sbq.pop_front();
            drive(v);
            n_vec++;
            if ({power_switch, cut_active, fault, cut_count} !== {v.exp, v.cc}) begin
                n_err++;
                $display("FAIL saturate e%0d: got ps/ca/flt=%b%b%b cnt=%0d, want %b cnt=%0d",
                         edge_n, power_switch, cut_active, fault, cut_count, v.exp, v.cc);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cut();
        test_blank();
        test_fault();
        test_window_wrap();
        test_en_drop();
        test_reset_and_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
